// File: rtl/xclk_bus_tx.sv
// Source half of a toggle-handshake bus synchronizer: holds a word on the
// crossing bus, flags it with a request toggle, and waits for the ack toggle.
module xclk_bus_tx #(
    parameter int WIDTH       = 10,
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] xdata_o,
    output logic             xreq_o,
    input  logic             xack_i,
    output logic             done_o,
    output logic             err_o
);

    localparam int CW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_MAX = CW'(ACK_TIMEOUT);
    localparam bit TO_EN = (ACK_TIMEOUT > 0);

    typedef enum logic {
        IDLE,
        WAIT_ACK
    } state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       data_q, data_d;
    logic                   req_q, req_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   ack_s;

    assign ack_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            data_q  <= '0;
            req_q   <= 1'b0;
            sync_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            req_q   <= req_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = err_q;
        sync_d  = {sync_q[SYNC_STAGES-2:0], xack_i};

        unique case (state_q)
            IDLE: begin
                // An unsolicited ack here is a protocol violation; ignore it.
                if (valid_i) begin
                    data_d  = data_i;
                    req_d   = ~req_q;
                    cnt_d   = '0;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (cnt_q != TO_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
                // Timeout only flags; the transfer keeps waiting for its ack.
                if (TO_EN && (cnt_d == TO_MAX)) begin
                    err_d = 1'b1;
                end
                if (ack_s == req_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    assign ready_o = (state_q == IDLE);
    assign xdata_o = data_q;
    assign xreq_o  = req_q;
    assign done_o  = done_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_xclk_bus_tx.sv
// Bench for xclk_bus_tx: cycle-level reference model, vector table,
// hand-written corner sequences and a randomized destination.
module tb_xclk_bus_tx;

    localparam int W  = 10;
    localparam int S  = 2;
    localparam int TO = 8;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic [W-1:0] data_i = '0;
    logic         valid_i = 1'b0;
    logic         xack_i = 1'b0;
    logic         ready_o;
    logic [W-1:0] xdata_o;
    logic         xreq_o;
    logic         done_o;
    logic         err_o;

    xclk_bus_tx #(
        .WIDTH(W),
        .SYNC_STAGES(S),
        .ACK_TIMEOUT(TO)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .data_i (data_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .xdata_o(xdata_o),
        .xreq_o (xreq_o),
        .xack_i (xack_i),
        .done_o (done_o),
        .err_o  (err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_err    = 0;

    // reference model state
    bit           m_busy;
    bit           m_req;
    logic [W-1:0] m_data;
    bit           m_done;
    bit           m_err;
    int           m_acc_edge;
    bit           samp[$];

    // model destination
    bit           dest_en = 0;
    bit           dest_rand = 0;
    int           dcnt = 0;
    int           ddly = 3;
    logic [W-1:0] got[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0;
        m_req  = 0;
        m_data = '0;
        m_done = 0;
        m_err  = 0;
        m_acc_edge = 0;
        samp.delete();
    endtask

    // One clock edge seen from the spec: ack_s is the xack level sampled
    // S edges before this one.
    task automatic model_edge();
        int  e;
        bit  acks;
        if (rst_i) begin
            model_reset();
            return;
        end
        e    = samp.size();
        acks = (e >= S) ? samp[e-S] : 1'b0;
        samp.push_back(xack_i);
        m_done = 0;
        if (!m_busy) begin
            if (valid_i) begin
                m_busy = 1;
                m_req  = ~m_req;
                m_data = data_i;
                m_acc_edge = e;
            end
        end else begin
            if (TO > 0 && (e - m_acc_edge) >= TO) m_err = 1;
            if (acks == m_req) begin
                m_busy = 0;
                m_done = 1;
            end
        end
    endtask

    task automatic dest_drive();
        if (dest_en && (xreq_o != xack_i)) begin
            dcnt++;
            if (dcnt >= ddly) begin
                got.push_back(xdata_o);
                xack_i = ~xack_i;
                dcnt = 0;
                ddly = dest_rand ? int'($urandom_range(1, 4)) : 3;
            end
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        model_edge();
        #1;
        chk("ready", 32'(ready_o), 32'(!m_busy));
        chk("xreq",  32'(xreq_o),  32'(m_req));
        chk("xdata", 32'(xdata_o), 32'(m_data));
        chk("done",  32'(done_o),  32'(m_done));
        chk("err",   32'(err_o),   32'(m_err));
        dest_drive();
    endtask

    task automatic do_reset();
        dest_en = 0;
        dcnt = 0;
        valid_i = 0;
        xack_i = 0;
        rst_i = 1;
        step();
        step();
        rst_i = 0;
        step();
    endtask

    typedef struct {
        bit           valid;
        logic [W-1:0] data;
        bit           ack;
        bit           e_ready;
        bit           e_req;
        logic [W-1:0] e_data;
        bit           e_done;
    } vec_t;

    vec_t vt[9];

    initial begin
        logic [W-1:0] hold_w;
        logic [W-1:0] words[3];
        bit           seen;
        bit           prev_req;
        int           nd;
        int           ntog;
        int           widx;

        model_reset();
        vt[0] = '{1, 10'h2A5, 0, 0, 1, 10'h2A5, 0};
        vt[1] = '{0, 10'h000, 0, 0, 1, 10'h2A5, 0};
        vt[2] = '{0, 10'h000, 0, 0, 1, 10'h2A5, 0};
        vt[3] = '{0, 10'h000, 0, 0, 1, 10'h2A5, 0};
        vt[4] = '{0, 10'h000, 0, 0, 1, 10'h2A5, 0};
        vt[5] = '{0, 10'h000, 1, 0, 1, 10'h2A5, 0};
        vt[6] = '{0, 10'h000, 1, 0, 1, 10'h2A5, 0};
        vt[7] = '{0, 10'h000, 1, 1, 1, 10'h2A5, 1};
        vt[8] = '{0, 10'h000, 1, 1, 1, 10'h2A5, 0};

        // reset then 20 idle cycles
        do_reset();
        chk("rst_ready", 32'(ready_o), 1);
        chk("rst_xreq",  32'(xreq_o),  0);
        chk("rst_xdata", 32'(xdata_o), 0);
        for (int i = 0; i < 20; i++) step();

        // single transfer from the vector table
        for (int i = 0; i < 9; i++) begin
            valid_i = vt[i].valid;
            data_i  = vt[i].data;
            xack_i  = vt[i].ack;
            step();
            chk($sformatf("vec%0d_ready", i), 32'(ready_o), 32'(vt[i].e_ready));
            chk($sformatf("vec%0d_xreq", i),  32'(xreq_o),  32'(vt[i].e_req));
            chk($sformatf("vec%0d_xdata", i), 32'(xdata_o), 32'(vt[i].e_data));
            chk($sformatf("vec%0d_done", i),  32'(done_o),  32'(vt[i].e_done));
        end

        // hold stability with the timeout running out
        hold_w  = W'($urandom);
        data_i  = hold_w;
        valid_i = 1;
        step();
        for (int i = 1; i <= 10; i++) begin
            data_i  = W'($urandom);
            valid_i = 1;
            step();
            chk("hold_xdata", 32'(xdata_o), 32'(hold_w));
            chk("hold_xreq",  32'(xreq_o),  0);
            chk("hold_ready", 32'(ready_o), 0);
            chk("hold_err",   32'(err_o),   32'(i >= TO));
        end
        valid_i = 0;
        xack_i  = 0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (ready_o) seen = 1;
        end
        chk("late_ack_idle", 32'(seen),   1);
        chk("late_ack_err",  32'(err_o),  1);
        chk("late_ack_done", 32'(done_o), 1);

        // back-to-back words, destination acks after 3 cycles
        do_reset();
        chk("b2b_err_clear", 32'(err_o), 0);
        words[0] = 10'h001;
        words[1] = 10'h3FF;
        words[2] = 10'h155;
        got.delete();
        dest_en = 1;
        dest_rand = 0;
        ddly = 3;
        widx = 0;
        nd = 0;
        ntog = 0;
        prev_req = xreq_o;
        valid_i = 1;
        data_i = words[0];
        for (int i = 0; i < 80 && nd < 3; i++) begin
            step();
            if (done_o) nd++;
            if (xreq_o != prev_req) begin
                ntog++;
                widx++;
                if (widx < 3) data_i = words[widx];
                else valid_i = 0;
            end
            prev_req = xreq_o;
        end
        valid_i = 0;
        chk("b2b_done_cnt", 32'(nd), 3);
        chk("b2b_tog_cnt",  32'(ntog), 3);
        chk("b2b_final_req", 32'(xreq_o), 1);
        chk("b2b_got_cnt", 32'(got.size()), 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("b2b_word%0d", i),
                (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF,
                32'(words[i]));
        end

        // randomized traffic against the model
        do_reset();
        dest_en = 1;
        dest_rand = 1;
        ddly = 2;
        for (int i = 0; i < 400; i++) begin
            valid_i = ($urandom_range(0, 1) == 1);
            data_i  = W'($urandom);
            step();
        end
        valid_i = 0;

        // asynchronous reset during WAIT_ACK
        do_reset();
        data_i  = 10'h1C3;
        valid_i = 1;
        step();
        valid_i = 0;
        step();
        step();
        chk("arst_pre_busy", 32'(ready_o), 0);
        #3;
        rst_i = 1;
        #1;
        chk("arst_ready", 32'(ready_o), 1);
        chk("arst_xreq",  32'(xreq_o),  0);
        chk("arst_xdata", 32'(xdata_o), 0);
        chk("arst_done",  32'(done_o),  0);
        chk("arst_err",   32'(err_o),   0);
        model_reset();
        step();
        rst_i = 0;
        step();
        chk("arst_release_ready", 32'(ready_o), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/xclk_bus_tx.md
# xclk_bus_tx

Source-side half of a toggle-handshake bus synchronizer. It captures a WIDTH-bit word from the local clock domain and holds it stable on a crossing bus. It signals each new word by toggling a request line, then waits for the destination domain to toggle an acknowledge line back. The destination side is a synchronizing register bank; this block drives its inputs and consumes its acknowledge.

## Interface

Parameters:
- WIDTH, 10, width of the transferred word.
- SYNC_STAGES, 2, flop stages on the incoming acknowledge (legal range 2..4).
- ACK_TIMEOUT, 1024, cycles allowed in WAIT_ACK before err_o is raised; 0 disables the timeout.

Ports:
- clk_i, input, 1, local clock; the only clock of the block.
- rst_i, input, 1, reset, asynchronous and active-high.
- data_i, input, WIDTH, word to send; sampled only on accept.
- valid_i, input, 1, word on data_i is valid.
- ready_o, output, 1, block can accept a word (IDLE state).
- xdata_o, output, WIDTH, crossing data bus; registered and held stable for the whole transfer.
- xreq_o, output, 1, request toggle; registered and glitch-free.
- xack_i, input, 1, acknowledge toggle from the other domain; asynchronous to clk_i.
- done_o, output, 1, one-cycle pulse when a transfer is acknowledged.
- err_o, output, 1, sticky acknowledge-timeout flag.

## Operation

- Accept condition: valid_i & ready_o at a rising clk_i edge.
- On accept: the hold register loads data_i, xreq_o inverts, and the state goes to WAIT_ACK.
- Acknowledge synchronizer: xack_i passes through SYNC_STAGES flops. ack_s is the last stage.
- Transfer complete: ack_s == xreq_o.
- States:
  - IDLE: ready_o=1. Accept moves to WAIT_ACK; otherwise stay in IDLE.
  - WAIT_ACK: ready_o=0. If ack_s == xreq_o, go to IDLE and pulse done_o; otherwise stay.
- valid_i in WAIT_ACK is ignored. No word is lost or queued, and data_i changes have no effect.
- xdata_o changes only on accept. It never changes while xreq_o != ack_s.
- Timeout counter:
  - Clears on entry to WAIT_ACK.
  - Increments each cycle in WAIT_ACK and saturates at ACK_TIMEOUT.
  - Width is clog2(ACK_TIMEOUT+1).
  - When it reaches ACK_TIMEOUT (ACK_TIMEOUT > 0), err_o is set.
- err_o stays set until rst_i. The state machine keeps waiting for the acknowledge; the toggle protocol cannot resynchronize if the block abandons a transfer.
- An unsolicited xack_i toggle while in IDLE makes ack_s != xreq_o. This is a protocol violation. The block still returns to IDLE; behavior beyond that is undefined and is not checked.

## Timing

- Reset values:
  - xdata_o = 0, xreq_o = 0, ready_o = 1, done_o = 0, err_o = 0.
  - Synchronizer flops = 0, timeout counter = 0, state = IDLE.
- Reset mid-transfer abandons the word. Both domains must be reset together; this is a system requirement.
- Accept at edge N: xdata_o and xreq_o update and ready_o falls, all visible after edge N.
- If xack_i toggles before edge K, ack_s reflects the toggle after edge K+SYNC_STAGES-1. The block returns to IDLE at edge K+SYNC_STAGES.
  - Example, SYNC_STAGES=2: ready_o=1 and done_o=1 are visible after edge K+2.
- done_o is high for exactly one cycle, in the same cycle as the first ready_o=1.
- Back-to-back: an accept during the done_o cycle is legal. xreq_o toggles again at the next edge, giving minimum one idle cycle of ready_o between transfers.
- Throughput is bounded by round-trip latency: destination sync plus SYNC_STAGES+1 local cycles.
- Timeout: err_o rises after edge N+ACK_TIMEOUT, where edge N is the accept edge, if the acknowledge has not been seen.
- Simultaneous timeout and acknowledge at the same edge: the return to IDLE happens and err_o is still set.

## Test plan

- Reset, then idle: after rst_i release, ready_o=1, xreq_o=0, xdata_o=0, done_o=0, err_o=0, held for 20 cycles with valid_i=0.
- Single transfer: data_i=10'h2A5, valid_i pulsed at edge N. Required: xdata_o=10'h2A5 and xreq_o=1 after N. Destination toggles xack_i before edge N+5, then done_o=1 and ready_o=1 after edge N+7 (SYNC_STAGES=2).
- Hold stability: during WAIT_ACK, drive valid_i=1 with random data_i for 10 cycles. Required: xdata_o, xreq_o unchanged; no second accept.
- Back-to-back: words 10'h001, 10'h3FF, 10'h155 with valid_i held high and a model destination with a 3-cycle acknowledge delay. Required: xreq_o toggles three times (0→1→0→1), three done_o pulses, and words arrive in order.
- Timeout: ACK_TIMEOUT=8, no acknowledge. Required: err_o=1 after edge N+8 and ready_o stays 0. A late acknowledge then returns the block to IDLE with err_o still 1.
- Reset mid-transfer: assert rst_i asynchronously during WAIT_ACK. Required: all outputs return to reset values immediately and ready_o=1 after release.
